pifo_flow_sched: RTL and testbench
==================================

Name: pifo_flow_sched

Overview:
- Flow-level scheduler wrapped around a pifo_set instance; the PIFO holds one entry per backlogged flow (data = flow id, prio = rank).
- Counts per-flow packet backlog from the arrival side. Pushes a flow into the PIFO when it becomes backlogged.
- Pops the head flow and emits a dequeue grant downstream. In the pop cycle, reinserts the flow with an aged rank if it is still backlogged.

Parameters:
- NUM_FLOWS, 16, number of flows; the attached pifo_set NUM_ELEMENTS must be >= NUM_FLOWS.
- MAX_PRIORITY, 256, rank range; PRIO_WIDTH = $clog2(MAX_PRIORITY).
- CNT_WIDTH, 8, per-flow backlog counter width.
- QUANTUM, 8, rank decrement applied on each reinsert.
- FLOW_WIDTH, $clog2(NUM_FLOWS), derived flow-id width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i__arr_valid  in  1  packet arrival for a flow
- i__arr_flow  in  FLOW_WIDTH  arriving flow id
- i__arr_priority  in  PRIO_WIDTH  initial rank, used only if the flow is idle
- o__arr_ready  out  1  arrival accepted this cycle (combinational)
- o__push_valid  out  1  to pifo_set i__push_valid
- o__push_priority  out  PRIO_WIDTH  to pifo_set i__push_priority
- o__push_data  out  FLOW_WIDTH  to pifo_set i__push_data
- i__push_ready  in  1  from pifo_set o__push_ready
- o__reinsert_priority  out  PRIO_WIDTH  to pifo_set; 0 = no reinsert
- i__pop_valid  in  1  from pifo_set o__pop_valid
- i__pop_priority  in  PRIO_WIDTH  head rank
- i__pop_data  in  FLOW_WIDTH  head flow id
- o__pop  out  1  to pifo_set i__pop
- o__clear_all  out  1  to pifo_set i__clear_all
- o__deq_valid  out  1  dequeue grant valid
- o__deq_flow  out  FLOW_WIDTH  granted flow
- o__deq_priority  out  PRIO_WIDTH  rank at grant
- i__deq_ready  in  1  downstream accepts the grant
- i__clear  in  1  flush all scheduler state

Behaviour:
- Reset is synchronous and active-high on clk.
  - All counters are 0, all active bits are 0, and deq_valid is 0.
  - o__push_valid, o__pop and o__reinsert_priority are 0 during reset.
- State:
  - r__cnt[NUM_FLOWS]: per-flow backlog.
  - r__active[NUM_FLOWS]: flow currently resident in the PIFO or in the pop cycle.
  - A 1-entry output register holding deq_valid/deq_flow/deq_priority.
- Arrival rank: arr_prio_c = max(i__arr_priority, 1). Rank 0 is reserved as the no-reinsert sentinel.
- Arrival acceptance (combinational):
  - o__arr_ready = ~reset & ~i__clear & (r__cnt[f] != max).
  - If r__active[f] == 0, o__arr_ready additionally requires i__push_ready.
- Accepted arrival to an idle flow:
  - Same cycle: o__push_valid = 1, push_priority = arr_prio_c, push_data = f.
  - Next cycle: r__active[f] = 1 and r__cnt[f] += 1.
- Accepted arrival to an active flow: r__cnt[f] += 1, no push.
- Pop issue: o__pop = i__pop_valid & (~deq_valid | i__deq_ready) & ~i__clear.
  - The pop is committed in the same cycle.
  - The output register loads {1, pop_data, pop_priority} at the next edge, so there is 1 cycle of latency from pop to grant.
- Reinsert, in the pop cycle only, for flow p = i__pop_data:
  - rem = r__cnt[p] - 1 + (accepted arrival to p this cycle).
  - rem > 0: o__reinsert_priority = (i__pop_priority > QUANTUM) ? i__pop_priority - QUANTUM : 1. r__active[p] stays 1.
  - rem == 0: o__reinsert_priority = 0 and r__active[p] is cleared.
  - A same-cycle arrival to p is always treated as active-flow: no push.
- Simultaneous events:
  - A push of flow a and a pop+reinsert of flow b in the same cycle is legal; pifo_set supports 2 inserts + 1 pop.
  - An arrival to flow p when p is popped in the same cycle is counted into rem. It never pushes a duplicate.
- Grant handshake:
  - deq_valid holds stable until i__deq_ready.
  - A grant and a new pop in the same cycle are allowed (back-to-back, 1 grant/cycle).
- i__clear:
  - Drives o__clear_all = 1.
  - Next cycle: all counters, active bits and deq_valid are 0.
  - Arrivals and pops that cycle are ignored.
- Invariant: every flow with r__cnt > 0 has exactly one entry in the PIFO, or is the flow being popped this cycle.

Decomposition:
- Shared package pifo_pkg: PRIO_WIDTH helper, the typedef FlowGrant {flow, prio}, and the constant REINSERT_NONE = 0.
- One sub-module, pifo_flow_sched_rank: combinational aging function (prio, QUANTUM) -> saturated-at-1 rank.
- pifo_set stays external and is wired at the top level.

Test Plan:
- Single flow:
  - Stimulus: after reset, one arrival on flow 3 with prio 0.
  - Required: push with prio 1. Then pop → grant flow 3, prio 1, reinsert 0, and r__active[3] returns to 0.
- Backlogged flow aging:
  - Stimulus: 3 arrivals on flow 5 with prio 40, deq_ready = 1.
  - Required: grants at prio 40, 32, 24. Reinserts are 32, 24, then 0.
- Saturation at rank 1:
  - Stimulus: flow 2 with prio 5 and 3 packets.
  - Required: reinserts are 1, then 0. Grants are 5, 1, 1.
- Pop/arrival collision:
  - Stimulus: flow 7 has count 1; arrival on 7 in its pop cycle.
  - Required: no push, reinsert nonzero, count stays 1, second grant for 7 follows.
- Backpressure:
  - Stimulus: deq_ready = 0 for 4 cycles with flows 1 and 4 backlogged.
  - Required: deq_valid held with flow unchanged, o__pop = 0, and two grants on consecutive cycles once ready is raised.
- Clear mid-operation:
  - Stimulus: i__clear with 10 packets queued.
  - Required: o__clear_all = 1 for 1 cycle, then deq_valid = 0 and all counters 0. A new arrival pushes again.

Source files
------------

// File: rtl/pifo_pkg.sv
// Shared types and constants for the PIFO flow scheduler and its rank helper.
package pifo_pkg;

  localparam int DEF_NUM_FLOWS    = 16;
  localparam int DEF_MAX_PRIORITY = 256;

  // Rank 0 on the reinsert port means "no reinsert"; live ranks never drop below RANK_MIN.
  localparam int REINSERT_NONE = 0;
  localparam int RANK_MIN      = 1;

  function automatic int prio_width(input int max_priority);
    return $clog2(max_priority);
  endfunction

  localparam int DEF_FLOW_WIDTH = $clog2(DEF_NUM_FLOWS);
  localparam int DEF_PRIO_WIDTH = prio_width(DEF_MAX_PRIORITY);

  typedef struct packed {
    logic [DEF_FLOW_WIDTH-1:0] flow;
    logic [DEF_PRIO_WIDTH-1:0] prio;
  } flow_grant_t;

endpackage

// File: rtl/pifo_flow_sched_rank.sv
// Rank aging for a reinserted flow: subtract QUANTUM, saturating at RANK_MIN.
module pifo_flow_sched_rank
  import pifo_pkg::*;
#(
  parameter int PRIO_WIDTH = 8,
  parameter int QUANTUM    = 8
) (
  input  logic [PRIO_WIDTH-1:0] prio,
  output logic [PRIO_WIDTH-1:0] aged
);

  localparam logic [PRIO_WIDTH-1:0] QUANT    = PRIO_WIDTH'(QUANTUM);
  localparam logic [PRIO_WIDTH-1:0] RANK_LOW = PRIO_WIDTH'(RANK_MIN);

  assign aged = (prio > QUANT) ? (prio - QUANT) : RANK_LOW;

endmodule

// File: rtl/pifo_flow_sched.sv
// Flow-level scheduler around an external pifo_set: one PIFO entry per backlogged flow,
// per-flow backlog counters, head pop to a 1-entry grant register, aged reinsert.
module pifo_flow_sched
  import pifo_pkg::*;
#(
  parameter int NUM_FLOWS    = 16,
  parameter int MAX_PRIORITY = 256,
  parameter int CNT_WIDTH    = 8,
  parameter int QUANTUM      = 8,
  parameter int PRIO_WIDTH   = prio_width(MAX_PRIORITY),
  parameter int FLOW_WIDTH   = $clog2(NUM_FLOWS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i__arr_valid,
  input  logic [FLOW_WIDTH-1:0] i__arr_flow,
  input  logic [PRIO_WIDTH-1:0] i__arr_priority,
  output logic                  o__arr_ready,
  output logic                  o__push_valid,
  output logic [PRIO_WIDTH-1:0] o__push_priority,
  output logic [FLOW_WIDTH-1:0] o__push_data,
  input  logic                  i__push_ready,
  output logic [PRIO_WIDTH-1:0] o__reinsert_priority,
  input  logic                  i__pop_valid,
  input  logic [PRIO_WIDTH-1:0] i__pop_priority,
  input  logic [FLOW_WIDTH-1:0] i__pop_data,
  output logic                  o__pop,
  output logic                  o__clear_all,
  output logic                  o__deq_valid,
  output logic [FLOW_WIDTH-1:0] o__deq_flow,
  output logic [PRIO_WIDTH-1:0] o__deq_priority,
  input  logic                  i__deq_ready,
  input  logic                  i__clear
);

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [PRIO_WIDTH-1:0] RANK_LOW = PRIO_WIDTH'(RANK_MIN);

  logic [CNT_WIDTH-1:0]  r__cnt [NUM_FLOWS];
  logic [NUM_FLOWS-1:0]  r__active;
  logic                  r__deq_valid;
  logic [FLOW_WIDTH-1:0] r__deq_flow;
  logic [PRIO_WIDTH-1:0] r__deq_priority;

  logic [PRIO_WIDTH-1:0] arr_prio_c;
  logic                  arr_ok;
  logic [CNT_WIDTH-1:0]  pop_cnt;
  logic                  rem_nz;
  logic [PRIO_WIDTH-1:0] aged_prio;
  logic [NUM_FLOWS-1:0]  arr_hit;
  logic [NUM_FLOWS-1:0]  pop_hit;

  pifo_flow_sched_rank #(
    .PRIO_WIDTH (PRIO_WIDTH),
    .QUANTUM    (QUANTUM)
  ) u_rank (
    .prio (i__pop_priority),
    .aged (aged_prio)
  );

  // Handshakes: an arrival transfers when i__arr_valid & o__arr_ready; a grant transfers
  // when o__deq_valid & i__deq_ready, and o__deq_valid/flow/priority hold until it does.
  always_comb begin
    arr_prio_c   = (i__arr_priority == '0) ? RANK_LOW : i__arr_priority;
    o__arr_ready = ~reset & ~i__clear & (r__cnt[i__arr_flow] != CNT_MAX)
                 & (r__active[i__arr_flow] | i__push_ready);
    arr_ok       = i__arr_valid & o__arr_ready;

    // A flow being popped is still active, so a same-cycle arrival never pushes a duplicate.
    o__push_valid    = arr_ok & ~r__active[i__arr_flow];
    o__push_priority = arr_prio_c;
    o__push_data     = i__arr_flow;

    o__pop  = ~reset & i__pop_valid & (~r__deq_valid | i__deq_ready) & ~i__clear;
    pop_cnt = r__cnt[i__pop_data];
    rem_nz  = (pop_cnt > CNT_ONE)
            | ((pop_cnt == CNT_ONE) & arr_ok & (i__arr_flow == i__pop_data));
    o__reinsert_priority = (o__pop & rem_nz) ? aged_prio : PRIO_WIDTH'(REINSERT_NONE);

    o__clear_all = i__clear;

    arr_hit = '0;
    pop_hit = '0;
    for (int i = 0; i < NUM_FLOWS; i++) begin
      arr_hit[i] = arr_ok & (i__arr_flow == FLOW_WIDTH'(i));
      pop_hit[i] = o__pop & (i__pop_data == FLOW_WIDTH'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i__clear) begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
        r__cnt[i] <= '0;
      end
      r__active       <= '0;
      r__deq_valid    <= 1'b0;
      r__deq_flow     <= '0;
      r__deq_priority <= '0;
    end else begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
        if (arr_hit[i] && !pop_hit[i]) begin
          r__cnt[i] <= r__cnt[i] + CNT_ONE;
        end else if (!arr_hit[i] && pop_hit[i]) begin
          r__cnt[i] <= r__cnt[i] - CNT_ONE;
        end
        if (pop_hit[i] && !rem_nz) begin
          r__active[i] <= 1'b0;
        end else if (arr_hit[i] && o__push_valid) begin
          r__active[i] <= 1'b1;
        end
      end
      if (o__pop) begin
        r__deq_valid    <= 1'b1;
        r__deq_flow     <= i__pop_data;
        r__deq_priority <= i__pop_priority;
      end else if (i__deq_ready) begin
        r__deq_valid <= 1'b0;
      end
    end
  end

  assign o__deq_valid    = r__deq_valid;
  assign o__deq_flow     = r__deq_flow;
  assign o__deq_priority = r__deq_priority;

endmodule

// File: tb/tb_pifo_flow_sched.sv
// Directed bench for pifo_flow_sched; the bench plays the pifo_set side by hand.
module tb_pifo_flow_sched;
  import pifo_pkg::*;

  localparam int FW = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          arr_valid;
  logic [FW-1:0] arr_flow;
  logic [PW-1:0] arr_priority;
  logic          arr_ready;
  logic          push_valid;
  logic [PW-1:0] push_priority;
  logic [FW-1:0] push_data;
  logic          push_ready;
  logic [PW-1:0] reinsert_priority;
  logic          pop_valid;
  logic [PW-1:0] pop_priority;
  logic [FW-1:0] pop_data;
  logic          pop;
  logic          clear_all;
  logic          deq_valid;
  logic [FW-1:0] deq_flow;
  logic [PW-1:0] deq_priority;
  logic          deq_ready;
  logic          clear;

  int n_pass  = 0;
  int n_total = 0;

  pifo_flow_sched dut (
    .clk                  (clk),
    .reset                (reset),
    .i__arr_valid         (arr_valid),
    .i__arr_flow          (arr_flow),
    .i__arr_priority      (arr_priority),
    .o__arr_ready         (arr_ready),
    .o__push_valid        (push_valid),
    .o__push_priority     (push_priority),
    .o__push_data         (push_data),
    .i__push_ready        (push_ready),
    .o__reinsert_priority (reinsert_priority),
    .i__pop_valid         (pop_valid),
    .i__pop_priority      (pop_priority),
    .i__pop_data          (pop_data),
    .o__pop               (pop),
    .o__clear_all         (clear_all),
    .o__deq_valid         (deq_valid),
    .o__deq_flow          (deq_flow),
    .o__deq_priority      (deq_priority),
    .i__deq_ready         (deq_ready),
    .i__clear             (clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_grant(input string tag, input flow_grant_t g);
    chk({tag, "_valid"}, 32'(deq_valid), 32'd1);
    chk({tag, "_flow"}, 32'(deq_flow), 32'(g.flow));
    chk({tag, "_prio"}, 32'(deq_priority), 32'(g.prio));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    arr_valid = 1'b0; arr_flow = '0; arr_priority = '0;
    pop_valid = 1'b0; pop_priority = '0; pop_data = '0;
    clear = 1'b0; push_ready = 1'b1; deq_ready = 1'b1;
  endtask

  task automatic arrive(input logic [FW-1:0] f, input logic [PW-1:0] p);
    arr_valid = 1'b1; arr_flow = f; arr_priority = p;
    tick();
    arr_valid = 1'b0;
  endtask

  task automatic set_pop(input logic [FW-1:0] f, input logic [PW-1:0] p);
    pop_valid = 1'b1; pop_data = f; pop_priority = p;
  endtask

  initial begin
    automatic int exp_grant[3];
    automatic int exp_re[3];
    flow_grant_t g;

    // Reset with activity on the inputs: nothing may leak out.
    idle();
    reset = 1'b1;
    arr_valid = 1'b1; arr_flow = 4'd3;
    set_pop(4'd3, 8'd9);
    tick();
    chk("rst_arr_ready", 32'(arr_ready), 32'd0);
    chk("rst_push_valid", 32'(push_valid), 32'd0);
    chk("rst_pop", 32'(pop), 32'd0);
    chk("rst_reinsert", 32'(reinsert_priority), 32'd0);
    tick();
    reset = 1'b0;
    idle();
    settle();
    chk("rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("rst_cnt3", 32'(dut.r__cnt[3]), 32'd0);

    // Single flow: prio 0 is lifted to 1.
    arr_valid = 1'b1; arr_flow = 4'd3; arr_priority = 8'd0;
    settle();
    chk("t1_arr_ready", 32'(arr_ready), 32'd1);
    chk("t1_push_valid", 32'(push_valid), 32'd1);
    chk("t1_push_prio", 32'(push_priority), 32'd1);
    chk("t1_push_data", 32'(push_data), 32'd3);
    tick();
    arr_valid = 1'b0;
    chk("t1_active", 32'(dut.r__active[3]), 32'd1);
    chk("t1_cnt", 32'(dut.r__cnt[3]), 32'd1);
    set_pop(4'd3, 8'd1);
    settle();
    chk("t1_pop", 32'(pop), 32'd1);
    chk("t1_reinsert", 32'(reinsert_priority), 32'd0);
    tick();
    pop_valid = 1'b0;
    g = '{flow: 4'd3, prio: 8'd1};
    chk_grant("t1_grant", g);
    chk("t1_active_clr", 32'(dut.r__active[3]), 32'd0);
    tick();
    chk("t1_deq_drain", 32'(deq_valid), 32'd0);

    // Backlogged flow aging: 3 packets on flow 5 at rank 40.
    arrive(4'd5, 8'd40);
    arr_valid = 1'b1; arr_flow = 4'd5; arr_priority = 8'd40;
    settle();
    chk("t2_no_push", 32'(push_valid), 32'd0);
    tick();
    arrive(4'd5, 8'd40);
    exp_grant = '{40, 32, 24};
    exp_re    = '{32, 24, 0};
    for (int k = 0; k < 3; k++) begin
      set_pop(4'd5, 8'(exp_grant[k]));
      settle();
      chk($sformatf("t2_pop%0d", k), 32'(pop), 32'd1);
      chk($sformatf("t2_re%0d", k), 32'(reinsert_priority), 32'(exp_re[k]));
      tick();
      g = '{flow: 4'd5, prio: 8'(exp_grant[k])};
      chk_grant($sformatf("t2_grant%0d", k), g);
    end
    pop_valid = 1'b0;
    tick();

    // Saturation at rank 1: flow 2, rank 5, 3 packets.
    arrive(4'd2, 8'd5);
    arrive(4'd2, 8'd5);
    arrive(4'd2, 8'd5);
    exp_grant = '{5, 1, 1};
    exp_re    = '{1, 1, 0};
    for (int k = 0; k < 3; k++) begin
      set_pop(4'd2, 8'(exp_grant[k]));
      settle();
      chk($sformatf("t3_re%0d", k), 32'(reinsert_priority), 32'(exp_re[k]));
      tick();
      g = '{flow: 4'd2, prio: 8'(exp_grant[k])};
      chk_grant($sformatf("t3_grant%0d", k), g);
    end
    pop_valid = 1'b0;
    tick();

    // Pop/arrival collision on flow 7.
    arrive(4'd7, 8'd20);
    set_pop(4'd7, 8'd20);
    arr_valid = 1'b1; arr_flow = 4'd7; arr_priority = 8'd99;
    settle();
    chk("t4_arr_ready", 32'(arr_ready), 32'd1);
    chk("t4_no_push", 32'(push_valid), 32'd0);
    chk("t4_reinsert", 32'(reinsert_priority), 32'd12);
    tick();
    arr_valid = 1'b0;
    chk("t4_cnt", 32'(dut.r__cnt[7]), 32'd1);
    chk("t4_active", 32'(dut.r__active[7]), 32'd1);
    g = '{flow: 4'd7, prio: 8'd20};
    chk_grant("t4_grant0", g);
    set_pop(4'd7, 8'd12);
    settle();
    chk("t4_reinsert_last", 32'(reinsert_priority), 32'd0);
    tick();
    pop_valid = 1'b0;
    g = '{flow: 4'd7, prio: 8'd12};
    chk_grant("t4_grant1", g);
    tick();

    // Idle flow cannot be accepted when the PIFO refuses the push.
    push_ready = 1'b0;
    arr_valid = 1'b1; arr_flow = 4'd9; arr_priority = 8'd3;
    settle();
    chk("bp_push_ready_arr", 32'(arr_ready), 32'd0);
    chk("bp_push_ready_push", 32'(push_valid), 32'd0);
    arr_valid = 1'b0;
    push_ready = 1'b1;
    tick();

    // Backpressure on the grant port with flows 1 and 4 backlogged.
    arrive(4'd1, 8'd10);
    arrive(4'd4, 8'd30);
    deq_ready = 1'b0;
    set_pop(4'd1, 8'd10);
    tick();
    set_pop(4'd4, 8'd30);
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("t5_pop_held%0d", k), 32'(pop), 32'd0);
      chk($sformatf("t5_valid%0d", k), 32'(deq_valid), 32'd1);
      chk($sformatf("t5_flow%0d", k), 32'(deq_flow), 32'd1);
      @(posedge clk);
    end
    #1;
    deq_ready = 1'b1;
    settle();
    chk("t5_pop_release", 32'(pop), 32'd1);
    tick();
    pop_valid = 1'b0;
    g = '{flow: 4'd4, prio: 8'd30};
    chk_grant("t5_grant_b2b", g);
    tick();
    chk("t5_drain", 32'(deq_valid), 32'd0);

    // Counter ceiling: 255 packets on flow 6, the 256th is refused.
    for (int k = 0; k < 255; k++) begin
      arrive(4'd6, 8'd50);
    end
    chk("sat_cnt", 32'(dut.r__cnt[6]), 32'd255);
    arr_valid = 1'b1; arr_flow = 4'd6; arr_priority = 8'd50;
    settle();
    chk("sat_arr_ready", 32'(arr_ready), 32'd0);
    tick();
    arr_valid = 1'b0;
    chk("sat_cnt_hold", 32'(dut.r__cnt[6]), 32'd255);

    // Clear mid-operation with 10 packets on flow 0 and a pending grant.
    for (int k = 0; k < 10; k++) begin
      arrive(4'd0, 8'd7);
    end
    deq_ready = 1'b0;
    set_pop(4'd0, 8'd7);
    tick();
    chk("t6_pending", 32'(deq_valid), 32'd1);
    clear = 1'b1;
    set_pop(4'd6, 8'd50);
    deq_ready = 1'b1;
    arr_valid = 1'b1; arr_flow = 4'd8; arr_priority = 8'd4;
    settle();
    chk("t6_clear_all", 32'(clear_all), 32'd1);
    chk("t6_pop_blocked", 32'(pop), 32'd0);
    chk("t6_arr_blocked", 32'(arr_ready), 32'd0);
    chk("t6_push_blocked", 32'(push_valid), 32'd0);
    tick();
    idle();
    settle();
    chk("t6_clear_all_off", 32'(clear_all), 32'd0);
    chk("t6_deq_valid", 32'(deq_valid), 32'd0);
    chk("t6_cnt0", 32'(dut.r__cnt[0]), 32'd0);
    chk("t6_cnt6", 32'(dut.r__cnt[6]), 32'd0);
    chk("t6_active6", 32'(dut.r__active[6]), 32'd0);
    chk("t6_cnt8", 32'(dut.r__cnt[8]), 32'd0);
    arr_valid = 1'b1; arr_flow = 4'd0; arr_priority = 8'd7;
    settle();
    chk("t6_repush", 32'(push_valid), 32'd1);
    chk("t6_repush_prio", 32'(push_priority), 32'd7);
    tick();
    arr_valid = 1'b0;
    chk("t6_recount", 32'(dut.r__cnt[0]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
